// File: rtl/line_feeder.sv
// line_feeder: host-side producer for the three-line filter datapath.
// Buffers a rolling window of three image rows and, for every filter pass,
// streams the oldest/middle/newest rows in lockstep on line1/line2/line3.
// While the filter works on a pass, the next row is loaded into the slot
// holding the oldest row, which the filter has already captured.
//
// Ports:
//   i_clk, i_rst          clock (rising edge) and async active-low reset
//   i_pix_valid/_data     host word stream in, o_pix_ack = word accepted
//   o_lineN_data_valid/_data, i_lineN_data_ack   row streams, N = 1..3
//   o_filter              start/hold request to the filter
//   i_row_done            filter finished the current pass (1-cycle pulse)
//   o_frame_done          1-cycle pulse after the last pass of a frame
//   o_busy                FSM is not idle
//
// States:
//   IDLE | waiting for the first host word of a frame
//   FILL | loading the first three rows into slots 0,1,2
//   SEND | streaming the three window rows to the filter
//   FILT | filter running; loading the next row into the oldest slot
module line_feeder #(
  parameter int LINE_WORDS = 64,
  parameter int IMG_ROWS   = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_valid,
  input  logic [63:0] i_pix_data,
  output logic        o_pix_ack,
  output logic        o_line1_data_valid,
  output logic [63:0] o_line1_data,
  input  logic        i_line1_data_ack,
  output logic        o_line2_data_valid,
  output logic [63:0] o_line2_data,
  input  logic        i_line2_data_ack,
  output logic        o_line3_data_valid,
  output logic [63:0] o_line3_data,
  input  logic        i_line3_data_ack,
  output logic        o_filter,
  input  logic        i_row_done,
  output logic        o_frame_done,
  output logic        o_busy
);
  localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int RW = $clog2(IMG_ROWS);
  localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMG_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND, FILT} state_t;
  state_t state;

  logic [63:0]   mem [3][LINE_WORDS];
  logic [63:0]   rd_data [3];
  logic [1:0]    wr_slot, base, mid_slot, new_slot;
  logic [WW-1:0] wr_word, rd_word, sent_cnt;
  logic [RW-1:0] row_idx;
  logic          rows_all, rd_done, s1_valid, out_valid, pix_ack;
  logic          next_full, done_flag, refilter;
  logic          wr_en, last_in, fire, out_take, s1_load, done_seen;

  // base is the oldest slot; the other two follow it mod 3
  always_comb begin
    mid_slot = (base == 2'd2) ? 2'd0 : base + 2'd1;
    new_slot = (base == 2'd0) ? 2'd2 : base - 2'd1;
  end

  assign wr_en     = i_pix_valid & pix_ack;
  assign last_in   = wr_en & (wr_word == LAST_WORD);
  assign fire      = out_valid & i_line1_data_ack & i_line2_data_ack & i_line3_data_ack;
  assign out_take  = ~out_valid | fire;
  // read stage refills whenever it is empty or its word moves to the output
  assign s1_load   = (state == SEND) & ~rd_done & (~s1_valid | out_take);
  assign done_seen = done_flag | i_row_done;

  assign o_pix_ack          = pix_ack;
  assign o_line1_data_valid = out_valid;
  assign o_line2_data_valid = out_valid;
  assign o_line3_data_valid = out_valid;
  assign o_busy             = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_slot][wr_word] <= i_pix_data;
    if (s1_load) begin
      for (int s = 0; s < 3; s++) rd_data[s] <= mem[s][rd_word];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      wr_slot      <= '0;
      base         <= '0;
      wr_word      <= '0;
      rd_word      <= '0;
      sent_cnt     <= '0;
      row_idx      <= '0;
      rows_all     <= 1'b0;
      rd_done      <= 1'b0;
      s1_valid     <= 1'b0;
      out_valid    <= 1'b0;
      pix_ack      <= 1'b0;
      next_full    <= 1'b0;
      done_flag    <= 1'b0;
      refilter     <= 1'b0;
      o_filter     <= 1'b0;
      o_frame_done <= 1'b0;
      o_line1_data <= '0;
      o_line2_data <= '0;
      o_line3_data <= '0;
    end else begin
      o_frame_done <= 1'b0;

      if (wr_en) begin
        if (wr_word == LAST_WORD) begin
          wr_word <= '0;
          if (row_idx == LAST_ROW) begin
            row_idx  <= '0;
            rows_all <= 1'b1;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end else begin
          wr_word <= wr_word + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (i_pix_valid) begin
            state    <= FILL;
            pix_ack  <= 1'b1;
            wr_slot  <= '0;
            wr_word  <= '0;
            row_idx  <= '0;
            rows_all <= 1'b0;
            base     <= '0;
            refilter <= 1'b0;
          end
        end

        FILL: begin
          if (last_in) begin
            if (wr_slot == 2'd2) begin
              state   <= SEND;
              pix_ack <= 1'b0;
            end else begin
              wr_slot <= wr_slot + 2'd1;
            end
          end
        end

        SEND: begin
          // restart request after the one-cycle gap between passes
          if (refilter) o_filter <= 1'b1;
          if (out_take) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
              o_line1_data <= rd_data[base];
              o_line2_data <= rd_data[mid_slot];
              o_line3_data <= rd_data[new_slot];
            end
          end
          if (s1_load) begin
            s1_valid <= 1'b1;
            if (rd_word == LAST_WORD) begin
              rd_word <= '0;
              rd_done <= 1'b1;
            end else begin
              rd_word <= rd_word + 1'b1;
            end
          end else if (out_take) begin
            s1_valid <= 1'b0;
          end
          if (fire) begin
            if (sent_cnt == LAST_WORD) begin
              sent_cnt  <= '0;
              out_valid <= 1'b0;
              s1_valid  <= 1'b0;
              rd_done   <= 1'b0;
              state     <= FILT;
              o_filter  <= 1'b1;
              pix_ack   <= ~rows_all;
              wr_slot   <= base;
              next_full <= 1'b0;
              done_flag <= 1'b0;
            end else begin
              sent_cnt <= sent_cnt + 1'b1;
            end
          end
        end

        FILT: begin
          if (i_row_done) done_flag <= 1'b1;
          if (last_in) begin
            pix_ack   <= 1'b0;
            next_full <= 1'b1;
          end
          if (done_seen && (next_full || last_in)) begin
            state     <= SEND;
            o_filter  <= 1'b0;
            refilter  <= 1'b1;
            base      <= mid_slot;
            done_flag <= 1'b0;
            next_full <= 1'b0;
          end else if (done_seen && rows_all && !next_full) begin
            state        <= IDLE;
            o_filter     <= 1'b0;
            o_frame_done <= 1'b1;
            refilter     <= 1'b0;
            done_flag    <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
